// File: rtl/ka163_mul_scheduler.sv
// Karatsuba sequencer: one 163-bit GF(2)[x] product from three 82-bit sub-products.
// KA_SCHED_PIPE_ISSUE_EN: issue all three requests back-to-back to a pipelined sub-multiplier.
module ka163_mul_scheduler #(
    parameter int unsigned N = 163,
    parameter int unsigned H = (N + 1) / 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           mul_req_valid,
    input  logic           mul_req_ready,
    output logic [H-1:0]   mul_a,
    output logic [H-1:0]   mul_b,
    input  logic           mul_rsp_valid,
    input  logic [2*H-2:0] mul_rsp_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] out_c,
    output logic           busy
);
    localparam int unsigned PW = 2 * H - 1;
    localparam int unsigned CW = 2 * N - 1;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCombine, StDone} state_t;

    state_t        state;
    logic [H-1:0]  a_l, a_h, b_l, b_h;
    logic [1:0]    issue_cnt, rsp_cnt;
    logic [PW-1:0] p_l, p_m, p_h;

    logic          req_fire;
    logic          rsp_fire;
    logic [PW-1:0] mid;
    logic [CW-1:0] combined;

    assign req_fire = mul_req_valid && mul_req_ready;
    // A response only counts while a request is outstanding.
    assign rsp_fire = mul_rsp_valid && (rsp_cnt != issue_cnt) &&
                      ((state == StIssue) || (state == StWait));

    assign mid      = p_l ^ p_m ^ p_h;
    assign combined = CW'(p_l) ^ (CW'(mid) << H) ^ (CW'(p_h) << (2 * H));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            in_ready      <= 1'b1;
            mul_req_valid <= 1'b0;
            mul_a         <= '0;
            mul_b         <= '0;
            out_valid     <= 1'b0;
            out_c         <= '0;
            busy          <= 1'b0;
            a_l           <= '0;
            a_h           <= '0;
            b_l           <= '0;
            b_h           <= '0;
            issue_cnt     <= '0;
            rsp_cnt       <= '0;
            p_l           <= '0;
            p_m           <= '0;
            p_h           <= '0;
        end else begin
            if (req_fire) begin
                issue_cnt <= issue_cnt + 2'd1;
                unique case (issue_cnt)
                    2'd0: begin
                        mul_a <= a_l ^ a_h;
                        mul_b <= b_l ^ b_h;
                    end
                    2'd1: begin
                        mul_a <= a_h;
                        mul_b <= b_h;
                    end
                    default: begin
                        mul_a <= '0;
                        mul_b <= '0;
                    end
                endcase
            end

            if (rsp_fire) begin
                rsp_cnt <= rsp_cnt + 2'd1;
                unique case (rsp_cnt)
                    2'd0:    p_l <= mul_rsp_data;
                    2'd1:    p_m <= mul_rsp_data;
                    default: p_h <= mul_rsp_data;
                endcase
            end

            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_l           <= in_a[H-1:0];
                        a_h           <= H'(in_a[N-1:H]);
                        b_l           <= in_b[H-1:0];
                        b_h           <= H'(in_b[N-1:H]);
                        mul_a         <= in_a[H-1:0];
                        mul_b         <= in_b[H-1:0];
                        issue_cnt     <= '0;
                        rsp_cnt       <= '0;
                        in_ready      <= 1'b0;
                        busy          <= 1'b1;
                        mul_req_valid <= 1'b1;
                        state         <= StIssue;
                    end
                end
                StIssue: begin
`ifdef KA_SCHED_PIPE_ISSUE_EN
                    if (req_fire && (issue_cnt == 2'd2)) begin
                        mul_req_valid <= 1'b0;
                        state         <= StWait;
                    end
`else
                    if (req_fire) begin
                        mul_req_valid <= 1'b0;
                        state         <= StWait;
                    end
`endif
                end
                StWait: begin
`ifdef KA_SCHED_PIPE_ISSUE_EN
                    if (rsp_cnt == 2'd3) begin
                        state <= StCombine;
                    end
`else
                    // Re-issue on the capture edge so the core sees no idle cycle.
                    if (rsp_cnt == 2'd3) begin
                        state <= StCombine;
                    end else if (rsp_fire && (issue_cnt != 2'd3)) begin
                        mul_req_valid <= 1'b1;
                        state         <= StIssue;
                    end
`endif
                end
                StCombine: begin
                    out_c     <= combined;
                    out_valid <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ka163_mul_scheduler.sv
// Directed bench for ka163_mul_scheduler with a fixed-latency sub-multiplier model.
module tb_ka163_mul_scheduler;
    localparam int N   = 163;
    localparam int H   = 82;
    localparam int LAT = 2;
`ifdef KA_SCHED_PIPE_ISSUE_EN
    localparam int EXP_LAT = 5 + LAT;
`else
    localparam int EXP_LAT = 5 + 3 * LAT;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   in_a = '0;
    logic [N-1:0]   in_b = '0;
    logic           mul_req_valid;
    logic           mul_req_ready = 1'b1;
    logic [H-1:0]   mul_a;
    logic [H-1:0]   mul_b;
    logic           mul_rsp_valid = 1'b0;
    logic [2*H-2:0] mul_rsp_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*N-2:0] out_c;
    logic           busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_acc = 0;
    int rsp_sent = 0;
    bit spur = 1'b0;

    int             due_q[$];
    logic [2*H-2:0] dat_q[$];
    logic [H-1:0]   req_a_q[$];
    logic [H-1:0]   req_b_q[$];

    ka163_mul_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .mul_req_valid (mul_req_valid),
        .mul_req_ready (mul_req_ready),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_rsp_valid (mul_rsp_valid),
        .mul_rsp_data  (mul_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_c         (out_c),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*H-2:0] clmul(input logic [H-1:0] x, input logic [H-1:0] y);
        logic [2*H-2:0] r;
        r = '0;
        for (int i = 0; i < H; i++)
            if (y[i]) r = r ^ ({{(H-1){1'b0}}, x} << i);
        return r;
    endfunction

    // Sub-multiplier: answers each request exactly LAT edges after its handshake.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            due_q.delete();
            dat_q.delete();
            mul_rsp_valid = 1'b0;
        end else begin
            if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
                mul_rsp_valid = 1'b1;
                mul_rsp_data  = dat_q.pop_front();
                void'(due_q.pop_front());
                rsp_sent++;
            end else if (spur) begin
                mul_rsp_valid = 1'b1;
                mul_rsp_data  = '1;
            end else begin
                mul_rsp_valid = 1'b0;
            end
            if (mul_req_valid && mul_req_ready) begin
                due_q.push_back(cyc + 1 + LAT);
                dat_q.push_back(clmul(mul_a, mul_b));
                req_a_q.push_back(mul_a);
                req_b_q.push_back(mul_b);
            end
        end
    end

    task automatic start_txn(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        t_acc    = cyc;
    endtask

    task automatic wait_result(output logic [2*N-2:0] c, output int lat, output bit to);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (out_valid) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        c   = out_c;
        lat = cyc - t_acc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        total++; if (mul_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got %b want 0", mul_req_valid); end
        total++; if (mul_a !== '0 || mul_b !== '0) begin bad++; $display("FAIL reset_mul_ab got %h %h want 0 0", mul_a, mul_b); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (out_c !== '0) begin bad++; $display("FAIL reset_out_c got %h want 0", out_c); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [2*N-2:0] c;
        logic [H-1:0]   ea[3];
        int             lat;
        int             base;
        bit             to;
        ea[0] = 1; ea[1] = 1; ea[2] = 0;
        base = req_a_q.size();
        start_txn(163'd1, 163'd1);
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy got busy=%b in_ready=%b want 1 0", busy, in_ready); end
        total++; if (mul_req_valid !== 1'b1 || mul_a !== 82'd1) begin bad++; $display("FAIL basic_first_req got v=%b a=%h want 1 1", mul_req_valid, mul_a); end
        wait_result(c, lat, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got timeout want out_valid"); end
        total++; if (c !== 325'd1) begin bad++; $display("FAIL basic_out_c got %h want 1", c); end
        total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL basic_latency got %0d want %0d", lat, EXP_LAT); end
        @(negedge clk);
        total++; if (req_a_q.size() - base !== 3) begin bad++; $display("FAIL basic_req_count got %0d want 3", req_a_q.size() - base); end
        for (int j = 0; j < 3; j++) begin
            total++;
            if (req_a_q[base+j] !== ea[j] || req_b_q[base+j] !== ea[j]) begin
                bad++;
                $display("FAIL basic_req%0d got %h %h want %h %h", j, req_a_q[base+j], req_b_q[base+j], ea[j], ea[j]);
            end
        end
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle got in_ready=%b busy=%b want 1 0", in_ready, busy); end
    endtask

    task automatic test_vectors();
        logic [N-1:0]   va[3];
        logic [N-1:0]   vb[3];
        logic [2*N-2:0] vc[3];
        logic [2*N-2:0] c;
        int             lat;
        bit             to;
        va[0] = '0; va[0][162] = 1'b1; vb[0] = va[0]; vc[0] = '0; vc[0][324] = 1'b1;
        va[1] = 163'd3; vb[1] = 163'd3; vc[1] = 325'd5;
        va[2] = '0; va[2][82] = 1'b1;
        vb[2] = '0; vb[2][81] = 1'b1; vb[2][0] = 1'b1;
        vc[2] = '0; vc[2][163] = 1'b1; vc[2][82] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_txn(va[k], vb[k]);
            wait_result(c, lat, to);
            total++; if (to) begin bad++; $display("FAIL vec%0d_timeout got timeout want out_valid", k); end
            total++; if (c !== vc[k]) begin bad++; $display("FAIL vec%0d_out_c got %h want %h", k, c, vc[k]); end
            @(negedge clk);
        end
    endtask

    task automatic test_spurious_rsp();
        logic [2*N-2:0] c;
        int             lat;
        bit             to;
        start_txn(163'd3, 163'd3);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        wait_result(c, lat, to);
        total++; if (to) begin bad++; $display("FAIL spur_timeout got timeout want out_valid"); end
        total++; if (c !== 325'd5) begin bad++; $display("FAIL spur_out_c got %h want 5", c); end
        total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL spur_latency got %0d want %0d", lat, EXP_LAT); end
        @(negedge clk);
    endtask

    task automatic test_req_stall();
        logic [N-1:0]   a;
        logic [2*N-2:0] exp_c;
        logic [2*N-2:0] c;
        int             lat;
        bit             to;
        bit             found;
        int             base;
        a = '0; a[82] = 1'b1; a[1] = 1'b1;
        exp_c = '0; exp_c[84] = 1'b1; exp_c[82] = 1'b1; exp_c[3] = 1'b1; exp_c[1] = 1'b1;
        base = req_a_q.size();
        start_txn(a, 163'd5);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mul_req_valid && mul_a == 82'd3) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL stall_find_req1 got none want mul_a=3 valid"); end
        mul_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (mul_req_valid !== 1'b1 || mul_a !== 82'd3 || mul_b !== 82'd5) begin
                bad++;
                $display("FAIL stall_hold%0d got v=%b a=%h b=%h want 1 3 5", i, mul_req_valid, mul_a, mul_b);
            end
        end
        mul_req_ready = 1'b1;
        wait_result(c, lat, to);
        total++; if (to) begin bad++; $display("FAIL stall_timeout got timeout want out_valid"); end
        total++; if (c !== exp_c) begin bad++; $display("FAIL stall_out_c got %h want %h", c, exp_c); end
        total++; if (lat !== EXP_LAT + 4) begin bad++; $display("FAIL stall_latency got %0d want %0d", lat, EXP_LAT + 4); end
        @(negedge clk);
        total++; if (req_a_q.size() - base !== 3) begin bad++; $display("FAIL stall_req_count got %0d want 3", req_a_q.size() - base); end
    endtask

    task automatic test_out_backpressure();
        logic [2*N-2:0] c;
        int             lat;
        bit             to;
        out_ready = 1'b0;
        start_txn(163'd3, 163'd3);
        wait_result(c, lat, to);
        total++; if (to) begin bad++; $display("FAIL bp_timeout got timeout want out_valid"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_c !== 325'd5 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b c=%h in_ready=%b want 1 5 0", i, out_valid, out_c, in_ready);
            end
        end
        // Offer the next operands on the handshake edge; they must wait a cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 163'd1;
        in_b      = 163'd1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_release got in_ready=%b v=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
        @(negedge clk);
        in_valid = 1'b0;
        t_acc    = cyc;
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_reaccept got busy=%b in_ready=%b want 1 0", busy, in_ready); end
        wait_result(c, lat, to);
        total++; if (to || c !== 325'd1) begin bad++; $display("FAIL bp_next_result got to=%b c=%h want 0 1", to, c); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0]   a;
        logic [2*N-2:0] c;
        int             lat;
        int             base;
        bit             to;
        bit             found;
        a = '0; a[162] = 1'b1; a[5] = 1'b1;
        base = rsp_sent;
        start_txn(a, a);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_sent - base == 1 && !mul_req_valid && busy) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL rstmid_find_wait got none want WAIT after 1 capture"); end
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got in_ready=%b busy=%b want 1 0", in_ready, busy); end
        total++; if (mul_req_valid !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin bad++; $display("FAIL rstmid_req got v=%b a=%h b=%h want 0 0 0", mul_req_valid, mul_a, mul_b); end
        total++; if (out_valid !== 1'b0 || out_c !== '0) begin bad++; $display("FAIL rstmid_out got v=%b c=%h want 0 0", out_valid, out_c); end
        @(negedge clk);
        rst = 1'b0;
        start_txn(163'd3, 163'd3);
        wait_result(c, lat, to);
        total++; if (to) begin bad++; $display("FAIL rstmid_timeout got timeout want out_valid"); end
        total++; if (c !== 325'd5) begin bad++; $display("FAIL rstmid_out_c got %h want 5", c); end
        total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL rstmid_latency got %0d want %0d", lat, EXP_LAT); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_spurious_rsp();
        test_req_stall();
        test_out_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
